lfm_chirp_analyzer: RTL and testbench

LFM_CHIRP_ANALYZER -- requirements
Module: lfm_chirp_analyzer

---
 rtl/lfm_chirp_analyzer.sv | 153 +++++++++++++++
 tb/tb_lfm_chirp_analyzer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/lfm_chirp_analyzer.sv
// rtl/lfm_chirp_analyzer.sv - LFM chirp period analyzer with hysteresis zero-crossing detection
//
// Measures the number of valid samples between consecutive rising midscale
// crossings of an unsigned chirp stream. A hysteresis comparator produces the
// level bit; a two-state tracker (SEARCH/TRACK) counts samples between
// crossings and flags loss of signal after MAX_PERIOD samples without one.
//
// Optional feature macro: LFM_RX_DELTA_EN
//   defined   : period-to-period delta output and sweep-restart strobe
//   undefined : delta, delta_valid and sweep_wrap tied to 0
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   din          in   DATA_W unsigned sample
//   din_valid    in   sample qualifier
//   period       out  CNT_W samples between rising crossings (held)
//   period_valid out  one-cycle strobe for period
//   timeout      out  one-cycle strobe on loss of signal
//   delta        out  CNT_W+1 signed, period minus previous period (held)
//   delta_valid  out  one-cycle strobe for delta
//   sweep_wrap   out  one-cycle strobe when delta > WRAP_TH
module lfm_chirp_analyzer #(
    parameter int DATA_W     = 10,
    parameter int MID        = 512,
    parameter int HYST       = 8,
    parameter int CNT_W      = 16,
    parameter int MAX_PERIOD = 4096,
    parameter int WRAP_TH    = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DATA_W-1:0]       din,
    input  logic                    din_valid,
    output logic [CNT_W-1:0]        period,
    output logic                    period_valid,
    output logic                    timeout,
    output logic signed [CNT_W:0]   delta,
    output logic                    delta_valid,
    output logic                    sweep_wrap
);

    localparam int HI_TH = MID + HYST;
    localparam int LO_TH = MID - HYST;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_PERIOD - 1);

    // Reject configurations whose timeout cannot be represented by the counter.
    if (MAX_PERIOD < 1 || MAX_PERIOD > (2 ** CNT_W) - 1 || WRAP_TH < 0) begin : g_bad_cfg
        $error("lfm_chirp_analyzer: invalid MAX_PERIOD/CNT_W/WRAP_TH");
    end

    typedef enum logic {SEARCH, TRACK} state_t;

    state_t           state;
    logic             lvl;
    logic             lvl_next;
    logic             crossing;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;

    // Hysteresis comparator: inside the dead band the previous level is held.
    always_comb begin
        lvl_next = lvl;
        if (int'(din) >= HI_TH)
            lvl_next = 1'b1;
        else if (int'(din) <= LO_TH)
            lvl_next = 1'b0;
        crossing = din_valid && !lvl && lvl_next;
        cnt_inc  = cnt + CNT_W'(1);
    end

`ifdef LFM_RX_DELTA_EN
    logic [CNT_W-1:0]      prev_period;
    logic                  prev_ok;      // prev_period belongs to the current track
    logic signed [CNT_W:0] delta_next;

    always_comb begin
        delta_next = $signed({1'b0, cnt_inc}) - $signed({1'b0, prev_period});
    end
`else
    assign delta       = '0;
    assign delta_valid = 1'b0;
    assign sweep_wrap  = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= SEARCH;
            lvl          <= 1'b0;
            cnt          <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            timeout      <= 1'b0;
`ifdef LFM_RX_DELTA_EN
            prev_period  <= '0;
            prev_ok      <= 1'b0;
            delta        <= '0;
            delta_valid  <= 1'b0;
            sweep_wrap   <= 1'b0;
`endif
        end else begin
            period_valid <= 1'b0;
            timeout      <= 1'b0;
`ifdef LFM_RX_DELTA_EN
            delta_valid  <= 1'b0;
            sweep_wrap   <= 1'b0;
`endif
            if (din_valid) begin
                lvl <= lvl_next;
                case (state)
                    SEARCH: begin
                        // First crossing only establishes the reference point.
                        if (crossing) begin
                            cnt   <= '0;
                            state <= TRACK;
`ifdef LFM_RX_DELTA_EN
                            prev_ok <= 1'b0;
`endif
                        end
                    end
                    TRACK: begin
                        if (crossing) begin
                            // The crossing sample itself closes the interval.
                            period       <= cnt_inc;
                            period_valid <= 1'b1;
                            cnt          <= '0;
`ifdef LFM_RX_DELTA_EN
                            if (prev_ok) begin
                                delta       <= delta_next;
                                delta_valid <= 1'b1;
                                sweep_wrap  <= (delta_next > WRAP_TH);
                            end
                            prev_period <= cnt_inc;
                            prev_ok     <= 1'b1;
`endif
                        end else if (cnt == CNT_LAST) begin
                            timeout <= 1'b1;
                            state   <= SEARCH;
                            cnt     <= '0;
`ifdef LFM_RX_DELTA_EN
                            prev_ok <= 1'b0;
`endif
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    default: state <= SEARCH;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lfm_chirp_analyzer.sv
// tb/tb_lfm_chirp_analyzer.sv - self-checking bench for lfm_chirp_analyzer
module tb_lfm_chirp_analyzer;

    localparam int DATA_W     = 10;
    localparam int MID        = 512;
    localparam int HYST       = 8;
    localparam int CNT_W      = 16;
    localparam int MAX_PERIOD = 4096;
    localparam int WRAP_TH    = 4;
`ifdef LFM_RX_DELTA_EN
    localparam bit DELTA_EN = 1'b1;
`else
    localparam bit DELTA_EN = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [DATA_W-1:0]     din = '0;
    logic                  din_valid = 1'b0;
    logic [CNT_W-1:0]      period;
    logic                  period_valid;
    logic                  timeout;
    logic signed [CNT_W:0] delta;
    logic                  delta_valid;
    logic                  sweep_wrap;

    lfm_chirp_analyzer #(
        .DATA_W(DATA_W), .MID(MID), .HYST(HYST), .CNT_W(CNT_W),
        .MAX_PERIOD(MAX_PERIOD), .WRAP_TH(WRAP_TH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
        .period(period), .period_valid(period_valid), .timeout(timeout),
        .delta(delta), .delta_valid(delta_valid), .sweep_wrap(sweep_wrap)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: works on absolute valid-sample indices.
    int vidx;
    int ref_idx;
    bit have_ref;
    bit m_lvl;
    int prev_p;
    bit prev_ok;
    int e_period, e_delta;
    bit e_pv, e_to, e_dv, e_wrap;
    int pv_seen, to_seen, wrap_seen;

    task automatic check(input string tag, input int got, input int exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".period"},       int'(period),         e_period);
        check({tag, ".period_valid"}, int'(period_valid),   int'(e_pv));
        check({tag, ".timeout"},      int'(timeout),        int'(e_to));
        check({tag, ".delta"},        int'(delta),          e_delta);
        check({tag, ".delta_valid"},  int'(delta_valid),    int'(e_dv));
        check({tag, ".sweep_wrap"},   int'(sweep_wrap),     int'(e_wrap));
        if (period_valid === 1'b1 && timeout === 1'b1)
            check({tag, ".pv_and_to"}, 1, 0);
        if (period_valid === 1'b1) pv_seen++;
        if (timeout === 1'b1) to_seen++;
        if (sweep_wrap === 1'b1) wrap_seen++;
    endtask

    task automatic model_reset();
        vidx = 0; ref_idx = 0; have_ref = 0; m_lvl = 0; prev_p = 0; prev_ok = 0;
        e_period = 0; e_delta = 0; e_pv = 0; e_to = 0; e_dv = 0; e_wrap = 0;
    endtask

    task automatic step(input int d, input bit v, input string tag);
        bit nl;
        int p;
        @(negedge clk);
        din = DATA_W'(d);
        din_valid = v;
        e_pv = 0; e_to = 0; e_dv = 0; e_wrap = 0;
        if (v) begin
            vidx++;
            nl = (d >= MID + HYST) ? 1'b1 : (d <= MID - HYST) ? 1'b0 : m_lvl;
            if (!m_lvl && nl) begin
                if (have_ref) begin
                    p = vidx - ref_idx;
                    e_period = p;
                    e_pv = 1;
                    if (DELTA_EN && prev_ok) begin
                        e_delta = p - prev_p;
                        e_dv = 1;
                        e_wrap = (e_delta > WRAP_TH);
                    end
                    prev_p = p;
                    prev_ok = 1;
                end else begin
                    have_ref = 1;
                    prev_ok = 0;
                end
                ref_idx = vidx;
            end else if (have_ref && (vidx - ref_idx) == MAX_PERIOD) begin
                e_to = 1;
                have_ref = 0;
                prev_ok = 0;
            end
            m_lvl = nl;
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        din_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One cycle of length p: a single high sample followed by p-1 low samples.
    task automatic spike_cycle(input int p, input string tag);
        step(1023, 1, tag);
        for (int i = 1; i < p; i++) step(0, 1, tag);
    endtask

    initial begin
        model_reset();
        #2;
        check_all("reset");
        do_reset("reset_rel");

        // Square wave 0/1023, period 16, continuous valid.
        pv_seen = 0;
        for (int c = 0; c < 6; c++) begin
            for (int i = 0; i < 8; i++) step(0, 1, "sq16");
            for (int i = 0; i < 8; i++) step(1023, 1, "sq16");
        end
        check("sq16.strobes", pv_seen, 5);
        check("sq16.period", int'(period), 16);

        // Dead-band dither: no crossing, no strobes.
        do_reset("rst_dither");
        pv_seen = 0; to_seen = 0;
        for (int i = 0; i < 60; i++) step((i % 2) ? 514 : 510, 1, "dither");
        check("dither.strobes", pv_seen + to_seen, 0);

        // Loss of signal after one crossing.
        do_reset("rst_timeout");
        to_seen = 0; pv_seen = 0;
        step(0, 1, "to");
        step(1023, 1, "to");
        for (int i = 0; i < MAX_PERIOD; i++) step(1023, 1, "to");
        check("to.count", to_seen, 1);
        step(0, 1, "to_after");
        step(1023, 1, "to_after");
        step(0, 1, "to_after");
        check("to.no_period", pv_seen, 0);

        // Chirp period sequence 20,18,16,40.
        do_reset("rst_chirp");
        wrap_seen = 0;
        spike_cycle(20, "chirp");
        spike_cycle(18, "chirp");
        spike_cycle(16, "chirp");
        spike_cycle(40, "chirp");
        step(1023, 1, "chirp");
        check("chirp.period", int'(period), 40);
        check("chirp.wraps", wrap_seen, DELTA_EN ? 1 : 0);

        // Randomized periods with invalid gaps carrying garbage samples.
        do_reset("rst_rand");
        for (int c = 0; c < 60; c++) begin
            int p;
            p = $urandom_range(4, 70);
            step($urandom_range(520, 1023), 1, "rand");
            for (int i = 1; i < p; i++) begin
                while ($urandom_range(0, 3) == 0) step($urandom_range(0, 1023), 0, "rand_gap");
                if ($urandom_range(0, 5) == 0) step($urandom_range(505, 519), 1, "rand");
                else step($urandom_range(0, 504), 1, "rand");
            end
        end

        // Period-16 wave, valid every other cycle, then reset mid-period.
        do_reset("rst_half");
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < 16; i++) begin
                step((i < 8) ? 0 : 1023, 1, "half");
                step($urandom_range(0, 1023), 0, "half_gap");
            end
        end
        check("half.period", int'(period), 16);
        for (int i = 0; i < 5; i++) step(0, 1, "half_pre");
        do_reset("rst_mid");
        pv_seen = 0;
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < 8; i++) step(1023, 1, "after_rst");
            for (int i = 0; i < 8; i++) step(0, 1, "after_rst");
        end
        check("after_rst.strobes", pv_seen, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
